// File: rtl/input_trigger_mc.sv
// Multi-channel push-button trigger: per-channel 2-FF sync, edge detect and lockout
// debounce, plus a shared settle sequencer that emits one refresh pulse per burst.
module input_trigger_mc #(
  parameter int CHANNELS        = 6,
  parameter int CNT_W           = 14,
  parameter int DEBOUNCE_CYCLES = 16380,
  parameter int SETTLE_CYCLES   = 10
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [CHANNELS-1:0] trigger,
  input  logic [CHANNELS-1:0] enable,
  input  logic [1:0]          edge_sel,
  input  logic                clr_dropped,
  output logic [CHANNELS-1:0] inc_pulse,
  output logic                inc_any,
  output logic                ref_pulse,
  output logic [CHANNELS-1:0] dropped,
  output logic                busy
);

  localparam logic [CNT_W-1:0] DEB_LOAD    = CNT_W'(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SETTLE  = 2'd1,
    REFRESH = 2'd2
  } state_t;

  logic [CHANNELS-1:0] sync1;
  logic [CHANNELS-1:0] trig_s;
  logic [CHANNELS-1:0] prev;
  logic [CHANNELS-1:0] rise;
  logic [CHANNELS-1:0] fall;
  logic [CHANNELS-1:0] edge_det;
  logic [CHANNELS-1:0] lock_zero;
  logic [CHANNELS-1:0] evt;
  logic [CHANNELS-1:0] drop_set;
  logic                any_evt;
  logic [CNT_W-1:0]    lock_cnt [CHANNELS];

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] settle_cnt;
  logic [CNT_W-1:0] settle_nxt;
  logic             ref_nxt;

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values; blocking here would collapse the two sync stages into one.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1  <= '0;
      trig_s <= '0;
      prev   <= '0;
    end else begin
      sync1  <= trigger;
      trig_s <= sync1;
      prev   <= trig_s;
    end
  end

  assign rise = trig_s & ~prev;
  assign fall = ~trig_s & prev;

  // NOTE: every always_comb output gets a default before the case so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    edge_det = '0;
    case (edge_sel)
      2'b00:   edge_det = rise;
      2'b01:   edge_det = fall;
      2'b10:   edge_det = rise | fall;
      default: edge_det = '0;
    endcase
  end

  always_comb begin
    for (int ch = 0; ch < CHANNELS; ch++) begin
      lock_zero[ch] = (lock_cnt[ch] == '0);
    end
  end

  // A locked channel swallows its edge and only records that it happened.
  assign evt      = edge_det & enable & lock_zero;
  assign drop_set = edge_det & enable & ~lock_zero;
  assign any_evt  = |evt;

  // NOTE: the lockout counter array is reset explicitly; it is control state, not a
  // data memory, and a stale count after reset would mask the first press.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int ch = 0; ch < CHANNELS; ch++) begin
        lock_cnt[ch] <= '0;
      end
    end else begin
      for (int ch = 0; ch < CHANNELS; ch++) begin
        if (evt[ch]) begin
          lock_cnt[ch] <= DEB_LOAD;
        end else if (!lock_zero[ch]) begin
          lock_cnt[ch] <= lock_cnt[ch] - CNT_ONE;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      inc_pulse <= '0;
      inc_any   <= 1'b0;
      dropped   <= '0;
    end else begin
      inc_pulse <= evt;
      inc_any   <= any_evt;
      dropped   <= drop_set | (clr_dropped ? '0 : dropped);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      settle_cnt <= '0;
      ref_pulse  <= 1'b0;
    end else begin
      state      <= state_nxt;
      settle_cnt <= settle_nxt;
      ref_pulse  <= ref_nxt;
    end
  end

  // Any new event restarts the settle window so the refresh follows the last press.
  always_comb begin
    state_nxt  = state;
    settle_nxt = settle_cnt;
    case (state)
      IDLE: begin
        if (any_evt) begin
          state_nxt  = SETTLE;
          settle_nxt = SETTLE_LOAD;
        end
      end
      SETTLE: begin
        if (any_evt) begin
          settle_nxt = SETTLE_LOAD;
        end else if (settle_cnt == '0) begin
          state_nxt = REFRESH;
        end else begin
          settle_nxt = settle_cnt - CNT_ONE;
        end
      end
      REFRESH: begin
        if (any_evt) begin
          state_nxt  = SETTLE;
          settle_nxt = SETTLE_LOAD;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt  = IDLE;
        settle_nxt = '0;
      end
    endcase
  end

  always_comb begin
    ref_nxt = (state == SETTLE) && !any_evt && (settle_cnt == '0);
    busy    = (state != IDLE) || !(&lock_zero);
  end

endmodule

// File: tb/tb_input_trigger_mc.sv
// Scoreboard bench for input_trigger_mc: tests push expected pulses with their cycle,
// a negedge monitor pops and compares whenever the DUT pulses.
module tb_input_trigger_mc;

  localparam int CH  = 6;
  localparam int CW  = 14;
  localparam int DEB = 20;
  localparam int SET = 4;

  logic          clk;
  logic          reset;
  logic [CH-1:0] trigger;
  logic [CH-1:0] enable;
  logic [1:0]    edge_sel;
  logic          clr_dropped;
  logic [CH-1:0] inc_pulse;
  logic          inc_any;
  logic          ref_pulse;
  logic [CH-1:0] dropped;
  logic          busy;

  typedef struct {
    int            cyc;
    logic [CH-1:0] inc;
    logic          rp;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   cyc   = 0;
  int   n_vec = 0;
  int   n_err = 0;

  input_trigger_mc #(
    .CHANNELS(CH), .CNT_W(CW), .DEBOUNCE_CYCLES(DEB), .SETTLE_CYCLES(SET)
  ) dut (
    .clk(clk), .reset(reset), .trigger(trigger), .enable(enable),
    .edge_sel(edge_sel), .clr_dropped(clr_dropped), .inc_pulse(inc_pulse),
    .inc_any(inc_any), .ref_pulse(ref_pulse), .dropped(dropped), .busy(busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (sb.size() > 0 && sb[0].cyc < cyc) begin
      n_vec++;
      n_err++;
      $display("FAIL missed_output: cycle %0d saw nothing, required inc=%b ref=%b at cycle %0d",
               cyc, sb[0].inc, sb[0].rp, sb[0].cyc);
      void'(sb.pop_front());
    end
    if (inc_pulse !== '0 || inc_any !== 1'b0 || ref_pulse !== 1'b0) begin
      n_vec++;
      if (sb.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_output: cycle %0d inc=%b any=%b ref=%b, required no pulse",
                 cyc, inc_pulse, inc_any, ref_pulse);
      end else begin
        mon_e = sb.pop_front();
        if (cyc !== mon_e.cyc || inc_pulse !== mon_e.inc || inc_any !== (|mon_e.inc) ||
            ref_pulse !== mon_e.rp) begin
          n_err++;
          $display("FAIL pulse_compare: got cycle %0d inc=%b any=%b ref=%b, required cycle %0d inc=%b any=%b ref=%b",
                   cyc, inc_pulse, inc_any, ref_pulse, mon_e.cyc, mon_e.inc, |mon_e.inc, mon_e.rp);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic wait_drain(input int bound, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      if (sb.size() == 0 && busy === 1'b0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    n_vec++;
    if (inc_pulse !== '0 || inc_any !== 1'b0 || ref_pulse !== 1'b0) begin
      n_err++;
      $display("FAIL reset_pulses: inc=%b any=%b ref=%b, required 0", inc_pulse, inc_any, ref_pulse);
    end
    n_vec++;
    if (dropped !== '0 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL reset_flags: dropped=%b busy=%b, required 0/0", dropped, busy);
    end
    reset = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_single_press();
    int n;
    edge_sel = 2'b00;
    @(negedge clk);
    n = cyc;
    trigger[0] = 1'b1;
    sb.push_back(exp_t'{n + 3, 6'b000001, 1'b0});
    sb.push_back(exp_t'{n + 8, 6'b000000, 1'b1});
    wait_until(n + 3);
    n_vec++;
    if (busy !== 1'b1) begin
      n_err++;
      $display("FAIL single_busy_start: busy=%b, required 1", busy);
    end
    wait_until(n + 22);
    n_vec++;
    if (busy !== 1'b1) begin
      n_err++;
      $display("FAIL single_busy_lock_end: busy=%b, required 1", busy);
    end
    wait_until(n + 23);
    n_vec++;
    if (busy !== 1'b0) begin
      n_err++;
      $display("FAIL single_busy_fall: busy=%b, required 0", busy);
    end
    trigger[0] = 1'b0;
    repeat (5) @(negedge clk);
  endtask

  task automatic test_bounce();
    int n;
    bit ok;
    @(negedge clk);
    n = cyc;
    trigger[2] = 1'b1;
    sb.push_back(exp_t'{n + 3, 6'b000100, 1'b0});
    sb.push_back(exp_t'{n + 8, 6'b000000, 1'b1});
    for (int k = 1; k <= 5; k++) begin
      wait_until(n + 3 * k);
      trigger[2] = ~trigger[2];
    end
    wait_until(n + 25);
    n_vec++;
    if (dropped !== 6'b000100) begin
      n_err++;
      $display("FAIL bounce_dropped: dropped=%b, required 000100", dropped);
    end
    wait_drain(60, ok);
    n_vec++;
    if (!ok) begin
      n_err++;
      $display("FAIL bounce_drain: queue=%0d busy=%b, required empty/0", sb.size(), busy);
    end
    clr_dropped = 1'b1;
    @(negedge clk);
    clr_dropped = 1'b0;
    n_vec++;
    if (dropped !== '0) begin
      n_err++;
      $display("FAIL bounce_clear: dropped=%b, required 000000", dropped);
    end
  endtask

  task automatic test_parallel();
    int n;
    bit ok;
    @(negedge clk);
    n = cyc;
    trigger[1] = 1'b1;
    trigger[4] = 1'b1;
    sb.push_back(exp_t'{n + 3, 6'b010010, 1'b0});
    sb.push_back(exp_t'{n + 8, 6'b000000, 1'b1});
    wait_until(n + 10);
    trigger[1] = 1'b0;
    trigger[4] = 1'b0;
    wait_drain(60, ok);
    n_vec++;
    if (!ok) begin
      n_err++;
      $display("FAIL parallel_drain: queue=%0d busy=%b, required empty/0", sb.size(), busy);
    end
  endtask

  task automatic test_settle_restart();
    int n;
    bit ok;
    @(negedge clk);
    n = cyc;
    trigger[0] = 1'b1;
    sb.push_back(exp_t'{n + 3, 6'b000001, 1'b0});
    sb.push_back(exp_t'{n + 5, 6'b001000, 1'b0});
    sb.push_back(exp_t'{n + 10, 6'b000000, 1'b1});
    wait_until(n + 2);
    trigger[3] = 1'b1;
    wait_until(n + 12);
    trigger[0] = 1'b0;
    trigger[3] = 1'b0;
    wait_drain(60, ok);
    n_vec++;
    if (!ok) begin
      n_err++;
      $display("FAIL restart_drain: queue=%0d busy=%b, required empty/0", sb.size(), busy);
    end
  endtask

  task automatic test_modes();
    int n;
    bit ok;
    edge_sel = 2'b01;
    @(negedge clk);
    n = cyc;
    trigger[0] = 1'b1;
    wait_until(n + 5);
    trigger[0] = 1'b0;
    sb.push_back(exp_t'{n + 8, 6'b000001, 1'b0});
    sb.push_back(exp_t'{n + 13, 6'b000000, 1'b1});
    wait_drain(60, ok);
    n_vec++;
    if (!ok) begin
      n_err++;
      $display("FAIL falling_drain: queue=%0d busy=%b, required empty/0", sb.size(), busy);
    end

    edge_sel = 2'b10;
    @(negedge clk);
    n = cyc;
    trigger[0] = 1'b1;
    sb.push_back(exp_t'{n + 3, 6'b000001, 1'b0});
    sb.push_back(exp_t'{n + 8, 6'b000000, 1'b1});
    wait_until(n + 25);
    trigger[0] = 1'b0;
    sb.push_back(exp_t'{n + 28, 6'b000001, 1'b0});
    sb.push_back(exp_t'{n + 33, 6'b000000, 1'b1});
    wait_drain(60, ok);
    n_vec++;
    if (!ok) begin
      n_err++;
      $display("FAIL both_drain: queue=%0d busy=%b, required empty/0", sb.size(), busy);
    end

    edge_sel = 2'b00;
    enable[0] = 1'b0;
    @(negedge clk);
    n = cyc;
    trigger[0] = 1'b1;
    wait_until(n + 6);
    trigger[0] = 1'b0;
    wait_until(n + 12);
    n_vec++;
    if (dropped[0] !== 1'b0 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL disabled_channel: dropped[0]=%b busy=%b, required 0/0", dropped[0], busy);
    end
    enable[0] = 1'b1;
  endtask

  task automatic test_lockout_boundary();
    int n;
    bit ok;
    edge_sel = 2'b10;
    @(negedge clk);
    n = cyc;
    trigger[0] = 1'b1;
    sb.push_back(exp_t'{n + 3, 6'b000001, 1'b0});
    sb.push_back(exp_t'{n + 8, 6'b000000, 1'b1});
    wait_until(n + 20);
    trigger[0] = 1'b0;
    wait_until(n + 21);
    trigger[0] = 1'b1;
    sb.push_back(exp_t'{n + 24, 6'b000001, 1'b0});
    sb.push_back(exp_t'{n + 29, 6'b000000, 1'b1});
    wait_until(n + 22);
    n_vec++;
    if (dropped[0] !== 1'b0) begin
      n_err++;
      $display("FAIL boundary_pre_drop: dropped[0]=%b, required 0", dropped[0]);
    end
    clr_dropped = 1'b1;
    wait_until(n + 23);
    clr_dropped = 1'b0;
    n_vec++;
    if (dropped[0] !== 1'b1) begin
      n_err++;
      $display("FAIL boundary_set_wins: dropped[0]=%b, required 1", dropped[0]);
    end
    wait_until(n + 32);
    edge_sel = 2'b11;
    trigger[0] = 1'b0;
    wait_drain(60, ok);
    n_vec++;
    if (!ok || dropped !== 6'b000001) begin
      n_err++;
      $display("FAIL boundary_none_mode: drained=%b dropped=%b, required 1/000001", ok, dropped);
    end
    clr_dropped = 1'b1;
    @(negedge clk);
    clr_dropped = 1'b0;
    edge_sel = 2'b00;
    n_vec++;
    if (dropped !== '0) begin
      n_err++;
      $display("FAIL boundary_clear: dropped=%b, required 000000", dropped);
    end
  endtask

  task automatic test_reset_mid_settle();
    int n;
    int m;
    bit ok;
    @(negedge clk);
    n = cyc;
    trigger[5] = 1'b1;
    sb.push_back(exp_t'{n + 3, 6'b100000, 1'b0});
    wait_until(n + 5);
    reset = 1'b1;
    #1;
    n_vec++;
    if (inc_pulse !== '0 || inc_any !== 1'b0 || ref_pulse !== 1'b0 || dropped !== '0 ||
        busy !== 1'b0 || sb.size() != 0) begin
      n_err++;
      $display("FAIL midreset_outputs: inc=%b any=%b ref=%b dropped=%b busy=%b queue=%0d, required all 0",
               inc_pulse, inc_any, ref_pulse, dropped, busy, sb.size());
    end
    repeat (3) @(negedge clk);
    reset = 1'b0;
    m = cyc;
    sb.push_back(exp_t'{m + 3, 6'b100000, 1'b0});
    sb.push_back(exp_t'{m + 8, 6'b000000, 1'b1});
    wait_drain(60, ok);
    n_vec++;
    if (!ok) begin
      n_err++;
      $display("FAIL midreset_drain: queue=%0d busy=%b, required empty/0", sb.size(), busy);
    end
    trigger[5] = 1'b0;
    repeat (5) @(negedge clk);
  endtask

  initial begin
    reset       = 1'b1;
    trigger     = '0;
    enable      = '1;
    edge_sel    = 2'b00;
    clr_dropped = 1'b0;
    test_reset();
    test_single_press();
    test_bounce();
    test_parallel();
    test_settle_restart();
    test_modes();
    test_lockout_boundary();
    test_reset_mid_settle();
    repeat (5) @(negedge clk);
    n_vec++;
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL final_queue: %0d expected pulses outstanding, required 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
